// File: rtl/dmem_responder.sv
// dmem_responder: target end of the core's load/store interface.
// Accepts one word-addressed load/store at a time (valid/ready), performs the
// access LATENCY cycles after acceptance and returns a one-cycle response.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   req_valid     request present
//   req_ready     a request can be accepted on the coming edge
//   req_write     1 = store, 0 = load
//   req_addr      word address
//   req_wdata     store data
//   req_wstrb     byte-lane enables for stores (bit i -> bits 8i+7:8i)
//   resp_valid    one-cycle response pulse
//   resp_rdata    load data; 0 for stores and out-of-range accesses
//   resp_err      address out of range (qualified by resp_valid)
module dmem_responder #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_wstrb,
  output logic                resp_valid,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_err
);

  localparam int NB    = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // S_LAST: the access completes on the next edge. A new request may be
  // accepted on that same edge, which gives one request per LATENCY cycles.
  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_LAST
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              ready_q;
  logic              write_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [NB-1:0]     wstrb_q;
  logic              resp_valid_q;
  logic [DATA_W-1:0] resp_rdata_q;
  logic              resp_err_q;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              accept;
  logic              complete;
  logic              in_range;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] rd_word;

  assign req_ready  = ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

  assign accept   = req_valid && ready_q;
  assign complete = (state_q == S_LAST);
  assign in_range = ({1'b0, addr_q} < (ADDR_W + 1)'(DEPTH));
  assign idx      = addr_q[IDX_W-1:0];
  assign rd_word  = mem[idx];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = S_LAST;
      end
      S_LAST:  state_d = S_IDLE;
      default: ;
    endcase
    if (accept) begin
      cnt_d   = 4'(LATENCY - 1);
      state_d = (LATENCY == 1) ? S_LAST : S_WAIT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      ready_q      <= 1'b1;
      write_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ready_q      <= (state_d != S_WAIT);
      resp_valid_q <= complete;
      if (complete) begin
        resp_rdata_q <= (!write_q && in_range) ? rd_word : '0;
        resp_err_q   <= !in_range;
      end
      if (accept) begin
        write_q <= req_write;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        wstrb_q <= req_wstrb;
      end
    end
  end

  // Storage is not reset; reset only forces S_IDLE, so a pending store is dropped.
  always_ff @(posedge clk) begin
    if (complete && write_q && in_range) begin
      for (int unsigned b = 0; b < NB; b++) begin
        if (wstrb_q[b]) mem[idx][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  localparam int LAT [3] = '{2, 3, 1};
  localparam int DEP [3] = '{200, 256, 256};

  logic        clk;
  logic        rst_n;
  logic        rv [3];
  logic        rr [3];
  logic        rw [3];
  logic [7:0]  ra [3];
  logic [31:0] wd [3];
  logic [3:0]  ws [3];
  logic        sv [3];
  logic [31:0] sd [3];
  logic        se [3];

  logic [31:0] mdl [3][256];
  int n_chk  = 0;
  int n_pass = 0;

  dmem_responder #(.ADDR_W(8), .DATA_W(32), .DEPTH(200), .LATENCY(2)) u0 (
    .clk(clk), .rst_n(rst_n), .req_valid(rv[0]), .req_ready(rr[0]),
    .req_write(rw[0]), .req_addr(ra[0]), .req_wdata(wd[0]), .req_wstrb(ws[0]),
    .resp_valid(sv[0]), .resp_rdata(sd[0]), .resp_err(se[0]));

  dmem_responder #(.ADDR_W(8), .DATA_W(32), .DEPTH(256), .LATENCY(3)) u1 (
    .clk(clk), .rst_n(rst_n), .req_valid(rv[1]), .req_ready(rr[1]),
    .req_write(rw[1]), .req_addr(ra[1]), .req_wdata(wd[1]), .req_wstrb(ws[1]),
    .resp_valid(sv[1]), .resp_rdata(sd[1]), .resp_err(se[1]));

  dmem_responder #(.ADDR_W(8), .DATA_W(32), .DEPTH(256), .LATENCY(1)) u2 (
    .clk(clk), .rst_n(rst_n), .req_valid(rv[2]), .req_ready(rr[2]),
    .req_write(rw[2]), .req_addr(ra[2]), .req_wdata(wd[2]), .req_wstrb(ws[2]),
    .resp_valid(sv[2]), .resp_rdata(sd[2]), .resp_err(se[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Reference behaviour of one access: response value and memory effect.
  function automatic void model_op(input int i, input logic w, input logic [7:0] a,
                                   input logic [31:0] d, input logic [3:0] s,
                                   output logic [31:0] er, output logic ee);
    logic [31:0] m;
    er = 32'h0;
    ee = 1'b0;
    if (int'(a) >= DEP[i]) begin
      ee = 1'b1;
    end else if (w) begin
      for (int b = 0; b < 4; b++) begin
        if (s[b]) begin
          m = 32'hFF << (8 * b);
          mdl[i][a] = (mdl[i][a] & ~m) | (d & m);
        end
      end
    end else begin
      er = mdl[i][a];
    end
  endfunction

  // One complete transaction; call at #1 after a rising edge.
  task automatic txn(input int i, input logic w, input logic [7:0] a, input logic [31:0] d,
                     input logic [3:0] s, input string tag, output logic [31:0] obs);
    logic rdy;
    logic [31:0] er;
    logic ee;
    int n;
    n = 0;
    rv[i] = 1'b1; rw[i] = w; ra[i] = a; wd[i] = d; ws[i] = s;
    do begin
      rdy = rr[i];
      @(posedge clk); #1;
      n++;
    end while (!rdy && n < 50);
    rv[i] = 1'b0;
    chk({tag, "_accept"}, 32'(rdy), 32'd1);
    model_op(i, w, a, d, s, er, ee);
    chk({tag, "_ready_after_accept"}, 32'(rr[i]), (LAT[i] == 1) ? 32'd1 : 32'd0);
    for (int c = 1; c <= LAT[i]; c++) begin
      @(posedge clk); #1;
      if (c < LAT[i]) chk({tag, "_early_resp"}, 32'(sv[i]), 32'd0);
    end
    chk({tag, "_resp_valid"}, 32'(sv[i]), 32'd1);
    chk({tag, "_rdata"}, sd[i], er);
    chk({tag, "_err"}, 32'(se[i]), 32'(ee));
    chk({tag, "_ready_at_done"}, 32'(rr[i]), 32'd1);
    obs = sd[i];
    @(posedge clk); #1;
    chk({tag, "_pulse_end"}, 32'(sv[i]), 32'd0);
  endtask

  // Three loads with req_valid held high throughout.
  task automatic b2b(input int i, input string tag);
    logic rdy;
    logic exp_v;
    logic [31:0] exp_d;
    logic [7:0] a [3];
    int acc [3];
    logic [31:0] ed [3];
    int cyc;
    int j;
    a[0] = 8'd1; a[1] = 8'd2; a[2] = 8'd3;
    acc[0] = 0; acc[1] = 0; acc[2] = 0;
    cyc = 0;
    j = 0;
    rv[i] = 1'b1; rw[i] = 1'b0; ra[i] = a[0]; ws[i] = 4'h0; wd[i] = 32'h0;
    for (int n = 0; n < 40; n++) begin
      rdy = rr[i];
      @(posedge clk); #1;
      cyc++;
      exp_v = 1'b0;
      exp_d = 32'h0;
      for (int k = 0; k < j; k++) begin
        if (acc[k] + LAT[i] == cyc) begin
          exp_v = 1'b1;
          exp_d = ed[k];
        end
      end
      chk({tag, "_resp_valid"}, 32'(sv[i]), 32'(exp_v));
      if (exp_v) chk({tag, "_rdata"}, sd[i], exp_d);
      if (rdy && j < 3) begin
        acc[j] = cyc;
        ed[j] = mdl[i][a[j]];
        j++;
        if (j < 3) ra[i] = a[j];
        else rv[i] = 1'b0;
      end
      if (j == 3 && cyc == acc[2] + LAT[i]) break;
    end
    rv[i] = 1'b0;
    chk({tag, "_accepted"}, 32'(j), 32'd3);
    chk({tag, "_spacing1"}, 32'(acc[1] - acc[0]), 32'(LAT[i]));
    chk({tag, "_spacing2"}, 32'(acc[2] - acc[1]), 32'(LAT[i]));
    @(posedge clk); #1;
    chk({tag, "_idle_after"}, 32'(sv[i]), 32'd0);
  endtask

  initial begin
    logic [31:0] obs;
    logic rdy;
    for (int i = 0; i < 3; i++) begin
      rv[i] = 1'b0; rw[i] = 1'b0; ra[i] = 8'h0; wd[i] = 32'h0; ws[i] = 4'h0;
    end
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("reset_ready", 32'(rr[i]), 32'd1);
      chk("reset_valid", 32'(sv[i]), 32'd0);
      chk("reset_rdata", sd[i], 32'h0);
      chk("reset_err", 32'(se[i]), 32'd0);
    end

    // Fill every implemented word with a known random value.
    for (int i = 0; i < 3; i++) begin
      for (int a = 0; a < DEP[i]; a++) txn(i, 1'b1, 8'(a), $urandom, 4'hF, "prefill", obs);
    end

    txn(0, 1'b1, 8'h10, 32'hDEADBEEF, 4'hF, "st_full", obs);
    chk("st_full_rdata_zero", obs, 32'h0);
    txn(0, 1'b0, 8'h10, 32'h0, 4'h0, "ld_full", obs);
    chk("ld_full_value", obs, 32'hDEADBEEF);

    txn(0, 1'b1, 8'h20, 32'h11223344, 4'hF, "st_pre", obs);
    txn(0, 1'b1, 8'h20, 32'hAABBCCDD, 4'b0101, "st_lanes", obs);
    txn(0, 1'b0, 8'h20, 32'h0, 4'h0, "ld_lanes", obs);
    chk("ld_lanes_value", obs, 32'h11BB33DD);
    txn(0, 1'b1, 8'h20, 32'hFFFFFFFF, 4'h0, "st_nostrb", obs);
    txn(0, 1'b0, 8'h20, 32'h0, 4'h0, "ld_nostrb", obs);
    chk("ld_nostrb_value", obs, 32'h11BB33DD);

    txn(0, 1'b1, 8'hC7, 32'h12345678, 4'hF, "st_c7", obs);
    txn(0, 1'b0, 8'hC8, 32'h0, 4'h0, "ld_oor", obs);
    chk("ld_oor_err", 32'(se[0]), 32'd1);
    txn(0, 1'b1, 8'hC8, 32'h5A5A5A5A, 4'hF, "st_oor", obs);
    chk("st_oor_rdata", obs, 32'h0);
    txn(0, 1'b0, 8'hC7, 32'h0, 4'h0, "ld_c7", obs);
    chk("ld_c7_value", obs, 32'h12345678);

    b2b(1, "b2b_lat3");
    b2b(2, "b2b_lat1");

    // Randomized accesses, inst 0 covering out-of-range addresses too.
    for (int n = 0; n < 150; n++) begin
      int i;
      i = int'($urandom_range(0, 2));
      txn(i, 1'($urandom), 8'($urandom_range(0, 255)), $urandom, 4'($urandom), "rand", obs);
    end

    // Reset while a store is pending: it must never reach memory.
    txn(1, 1'b1, 8'h05, 32'h0, 4'hF, "st_05_zero", obs);
    rv[1] = 1'b1; rw[1] = 1'b1; ra[1] = 8'h05; wd[1] = 32'hCAFEF00D; ws[1] = 4'hF;
    rdy = rr[1];
    @(posedge clk); #1;
    rv[1] = 1'b0;
    chk("midrst_accept", 32'(rdy), 32'd1);
    @(posedge clk); #1;
    chk("midrst_busy", 32'(rr[1]), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("midrst_ready_async", 32'(rr[1]), 32'd1);
    chk("midrst_valid_async", 32'(sv[1]), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      chk("midrst_no_resp", 32'(sv[1]), 32'd0);
    end
    txn(1, 1'b0, 8'h05, 32'h0, 4'h0, "midrst_ld", obs);
    chk("midrst_ld_value", obs, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
